// File: rtl/ijvm_pkg.sv
// Shared constants and state encoding for the IJVM main memory model.
package ijvm_pkg;

  localparam int unsigned DefaultWordWidth = 8;
  localparam int unsigned DefaultAddrWidth = 8;

  // Wide enough for the largest legal read latency (15).
  localparam int unsigned LatCntWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReadWait,
    StReadDrive,
    StWriteAck
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, asynchronous (combinational) read.
module mem_array
  import ijvm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefaultWordWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] words_q [Depth];

  // No reset: contents survive a controller reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      words_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = words_q[raddr_i];

endmodule

// File: rtl/main_memory.sv
// Main memory controller: request FSM, fixed-latency read pipeline and shared
// tristate data bus in front of a mem_array.
module main_memory
  import ijvm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = DefaultWordWidth,
  parameter int unsigned ADDR_WIDTH   = DefaultAddrWidth,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  inout  wire  [WORD_WIDTH-1:0] mem,
  output logic                  mem_ready,
  output logic                  busy
);

  localparam logic [LatCntWidth-1:0] CntLoad = LatCntWidth'(READ_LATENCY - 1);
  localparam bit                     DirectDrive = (READ_LATENCY == 1);

  mem_state_e            state_q, state_d;
  logic [LatCntWidth-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   write_req;
  logic                   array_we;
  logic                   drive_en;
  logic [WORD_WIDTH-1:0]  rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A write beats a simultaneous read; the read stays pending upstream.
        if (mem_write) begin
          write_req = 1'b1;
          state_d   = StWriteAck;
        end else if (mem_read) begin
          addr_d  = addr;
          cnt_d   = CntLoad;
          state_d = DirectDrive ? StReadDrive : StReadWait;
        end
      end
      StReadWait: begin
        cnt_d = cnt_q - LatCntWidth'(1);
        if (cnt_q == LatCntWidth'(1)) begin
          state_d = StReadDrive;
        end
      end
      StReadDrive: state_d = StIdle;
      StWriteAck:  state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Reset outranks any request sampled at the same edge, including the store.
  assign array_we = write_req && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_ready = (state_q == StReadDrive) || (state_q == StWriteAck);
  assign busy      = (state_q == StReadWait) || (state_q == StReadDrive);

  // Yield the bus whenever the initiator is driving it for a write.
  assign drive_en = (state_q == StReadDrive) && !mem_write;
  assign mem      = drive_en ? rdata : {WORD_WIDTH{1'bz}};

  mem_array #(
    .WORD_WIDTH(WORD_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .clk_i  (clk),
    .we_i   (array_we),
    .waddr_i(addr),
    .wdata_i(mem),
    .raddr_i(addr_q),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: three instances (read latency 2, 1 and 15) on pulled-up buses.
module tb_main_memory;

  localparam int W  = 8;
  localparam int A  = 8;
  localparam int NI = 3;
  localparam logic [W-1:0] Pulled = 8'hFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [A-1:0] addr [NI];
  logic         rd   [NI];
  logic         wr   [NI];
  logic         oe   [NI];
  logic [W-1:0] wdat [NI];
  logic [W-1:0] bus_val [NI];
  logic         rdy  [NI];
  logic         bsy  [NI];

  function automatic int rl_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire [W-1:0] bus;
    pullup pu_bus (bus);
    assign bus = oe[g] ? wdat[g] : {W{1'bz}};
    assign bus_val[g] = bus;

    main_memory #(
      .WORD_WIDTH  (W),
      .ADDR_WIDTH  (A),
      .READ_LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr[g]),
      .mem_read (rd[g]),
      .mem_write(wr[g]),
      .mem      (bus),
      .mem_ready(rdy[g]),
      .busy     (bsy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           inst;
    logic [W-1:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int           inst;
    logic [A-1:0] a;
    logic [W-1:0] d;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input int i, input logic [A-1:0] a, input logic [W-1:0] d,
                       input string nm);
    addr[i] = a;
    wdat[i] = d;
    oe[i]   = 1'b1;
    wr[i]   = 1'b1;
    step();
    chk({nm, " ack"}, rdy[i], 1);
    chk({nm, " busy"}, bsy[i], 0);
    wr[i] = 1'b0;
    oe[i] = 1'b0;
    step();
    chk({nm, " ack drop"}, rdy[i], 0);
  endtask

  // Issues a read, pushes the expectation, and pops it when mem_ready shows up.
  task automatic rd_op(input int i, input logic [A-1:0] a, input logic [W-1:0] exp,
                       input bit chg_addr, input int pulse_at, input string nm);
    int  n;
    sb_t e;
    sb.push_back('{inst: i, data: exp});
    addr[i] = a;
    rd[i]   = 1'b1;
    step();
    if (chg_addr) addr[i] = a + 8'd1;
    n = 0;
    while (!rdy[i] && n < 40) begin
      chk({nm, " wait busy"}, bsy[i], 1);
      if (!oe[i]) chk({nm, " wait hiz"}, bus_val[i], Pulled);
      if (n == pulse_at) begin
        wr[i] = 1'b1; oe[i] = 1'b1; wdat[i] = 8'hFF;
      end else begin
        wr[i] = 1'b0; oe[i] = 1'b0;
      end
      step();
      n++;
    end
    wr[i] = 1'b0;
    oe[i] = 1'b0;
    chk({nm, " latency"}, n, rl_of(i) - 1);
    if (rdy[i]) begin
      e = sb.pop_front();
      chk({nm, " inst"}, i, e.inst);
      chk({nm, " data"}, bus_val[i], e.data);
      chk({nm, " drive busy"}, bsy[i], 1);
    end
    rd[i] = 1'b0;
    step();
    chk({nm, " done ready"}, rdy[i], 0);
    chk({nm, " done busy"}, bsy[i], 0);
    chk({nm, " done hiz"}, bus_val[i], Pulled);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; oe[i] = 1'b0; wdat[i] = '0;
    end
    reset = 1'b1;
    vt[0] = '{0, 8'h10, 8'hA5};
    vt[1] = '{0, 8'h12, 8'h5A};
    vt[2] = '{1, 8'h30, 8'hC3};
    vt[3] = '{1, 8'h31, 8'h01};
    vt[4] = '{2, 8'h40, 8'h7E};
    vt[5] = '{2, 8'h41, 8'h00};

    step();
    step();
    for (int i = 0; i < NI; i++) begin
      chk("reset ready", rdy[i], 0);
      chk("reset busy", bsy[i], 0);
      chk("reset hiz", bus_val[i], Pulled);
    end
    reset = 1'b0;
    step();

    // Table: write every vector, then read each back through the scoreboard.
    for (int k = 0; k < 6; k++) wr_op(vt[k].inst, vt[k].a, vt[k].d, "tbl write");
    for (int k = 0; k < 6; k++) rd_op(vt[k].inst, vt[k].a, vt[k].d, 1'b0, -1, "tbl read");

    // Simultaneous read+write: write wins, bus never driven by the block.
    addr[0] = 8'h20; wdat[0] = 8'h3C; oe[0] = 1'b1; wr[0] = 1'b1; rd[0] = 1'b1;
    step();
    chk("simul ack", rdy[0], 1);
    chk("simul busy", bsy[0], 0);
    wr[0] = 1'b0; rd[0] = 1'b0; oe[0] = 1'b0;
    #1;
    chk("simul hiz", bus_val[0], Pulled);
    step();
    chk("simul idle busy", bsy[0], 0);
    rd_op(0, 8'h20, 8'h3C, 1'b0, -1, "simul read");

    // Write pulsed during a long read is ignored; read returns the old word.
    wr_op(2, 8'h11, 8'h22, "pulse pre");
    rd_op(2, 8'h11, 8'h22, 1'b0, 2, "pulse read");
    rd_op(2, 8'h11, 8'h22, 1'b0, -1, "pulse ignored");

    // Write held through READ_DRIVE: bus released, write taken back in IDLE.
    wr_op(0, 8'h11, 8'h22, "hold pre");
    addr[0] = 8'h11; rd[0] = 1'b1;
    step();
    chk("hold wait busy", bsy[0], 1);
    wr[0] = 1'b1;
    step();
    chk("hold drive ready", rdy[0], 1);
    chk("hold drive hiz", bus_val[0], Pulled);
    rd[0] = 1'b0;
    step();
    chk("hold idle ready", rdy[0], 0);
    chk("hold idle busy", bsy[0], 0);
    oe[0] = 1'b1; wdat[0] = 8'h99;
    step();
    chk("hold write ack", rdy[0], 1);
    wr[0] = 1'b0; oe[0] = 1'b0;
    step();
    rd_op(0, 8'h11, 8'h99, 1'b0, -1, "hold read");

    // Reset mid-read, with a write request at the same edge that must not land.
    addr[0] = 8'h10; rd[0] = 1'b1;
    step();
    chk("rst mid busy", bsy[0], 1);
    rd[0] = 1'b0; reset = 1'b1; wr[0] = 1'b1; oe[0] = 1'b1; wdat[0] = 8'h00;
    step();
    chk("rst mid ready", rdy[0], 0);
    chk("rst mid busy low", bsy[0], 0);
    reset = 1'b0; wr[0] = 1'b0; oe[0] = 1'b0;
    #1;
    chk("rst mid hiz", bus_val[0], Pulled);
    step();
    chk("rst idle ready", rdy[0], 0);
    rd_op(0, 8'h10, 8'hA5, 1'b0, -1, "rst read");

    // Reset during a write acknowledge: ack cleared, stored word kept.
    addr[1] = 8'h50; wdat[1] = 8'h12; oe[1] = 1'b1; wr[1] = 1'b1;
    step();
    chk("rst ack ready", rdy[1], 1);
    wr[1] = 1'b0; oe[1] = 1'b0; reset = 1'b1;
    step();
    chk("rst ack cleared", rdy[1], 0);
    reset = 1'b0;
    step();
    rd_op(1, 8'h50, 8'h12, 1'b0, -1, "rst ack read");

    // Address moved after acceptance must not redirect the read.
    rd_op(0, 8'h10, 8'hA5, 1'b1, -1, "addr chg");
    rd_op(2, 8'h40, 8'h7E, 1'b1, -1, "addr chg long");

    chk("sb empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
